// File: rtl/hazard_pkg.sv
// Shared op-class encoding, default latencies and counter sizing for the ID-stage hazard scoreboard.
package hazard_pkg;

  typedef enum logic [1:0] {
    OPC_ALU  = 2'd0,
    OPC_LOAD = 2'd1,
    OPC_MDU  = 2'd2,
    OPC_RSVD = 2'd3
  } opClass_e;

  localparam int DEF_LOAD_LAT = 1;
  localparam int DEF_MDU_LAT  = 4;

  // Counter width able to hold the longest latency that can be written into an entry.
  function automatic int cntWidth(input int loadLat, input int mduLat);
    int maxLat;
    maxLat = (loadLat > mduLat) ? loadLat : mduLat;
    return $clog2(maxLat + 1);
  endfunction

endpackage

// File: rtl/hazard_sb_entry.sv
// One scoreboard countdown: load on issue, count down to zero, hold on freeze, async clear.
module hazard_sb_entry #(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rstN,
  input  logic          freeze,
  input  logic          load,
  input  logic [CW-1:0] loadVal,
  output logic          busy
);

  logic [CW-1:0] cnt;

  // NOTE: non-blocking assignments so every entry updates from the same pre-edge view of the pipeline.
  // NOTE: entries are plain flops with async clear (not a RAM), so reset wipes every pending hazard at once.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      cnt <= '0;
    end else if (!freeze) begin
      if (load) begin
        cnt <= loadVal;
      end else if (cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// ID-stage interlock: per-register countdown scoreboard plus MDU occupancy, producing PC/IF_ID hold and ID/EX bubble.
module hazard_scoreboard_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_SRC    = 2,
  parameter int LOAD_LAT   = DEF_LOAD_LAT,
  parameter int MDU_LAT    = DEF_MDU_LAT,
  parameter int ZERO_REG   = 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          id_valid_i,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src_addr_i,
  input  logic [NUM_SRC-1:0]            id_src_used_i,
  input  logic [REG_ADDR_W-1:0]         id_dst_addr_i,
  input  logic                          id_dst_we_i,
  input  logic [1:0]                    id_op_class_i,
  input  logic                          mem_stall_i,
  input  logic                          flush_i,
  output logic                          PC_Stall_o,
  output logic                          IF_ID_Stall_o,
  output logic                          stall_o,
  output logic [NUM_SRC-1:0]            hazard_src_o,
  output logic                          mdu_busy_o
);

  localparam int            NUM_REGS = 2 ** REG_ADDR_W;
  localparam int            CW       = cntWidth(LOAD_LAT, MDU_LAT);
  localparam logic [CW-1:0] LOAD_VAL = CW'(LOAD_LAT);
  localparam logic [CW-1:0] MDU_VAL  = CW'(MDU_LAT);

  opClass_e            opClass;
  logic                isLoad, isMdu, trackLoad;
  logic                dstTracked, writeIssue, mduLoad, mduBusy;
  logic [CW-1:0]       dstLoadVal;
  logic [NUM_REGS-1:0] regBusy;
  logic [NUM_SRC-1:0]  raw;
  logic                waw, strc, hz, issue;

  // Reserved class 2'd3 falls through both compares and behaves as ALU.
  assign opClass   = opClass_e'(id_op_class_i);
  assign isLoad    = (opClass == OPC_LOAD);
  assign isMdu     = (opClass == OPC_MDU);
  assign trackLoad = isLoad && (LOAD_LAT > 0);

  for (genvar i = 0; i < NUM_SRC; i++) begin : gSrc
    logic [REG_ADDR_W-1:0] srcAddr;
    assign srcAddr = id_src_addr_i[i*REG_ADDR_W +: REG_ADDR_W];
    assign raw[i]  = id_valid_i & id_src_used_i[i] & regBusy[srcAddr];
  end

  assign waw   = id_valid_i & id_dst_we_i & regBusy[id_dst_addr_i];
  assign strc  = id_valid_i & isMdu & mduBusy;
  assign hz    = (|raw) | waw | strc;
  assign issue = id_valid_i & ~hz & ~flush_i & ~mem_stall_i;

  assign PC_Stall_o    = hz & ~flush_i;
  assign IF_ID_Stall_o = hz & ~flush_i;
  assign stall_o       = hz & ~flush_i;
  assign hazard_src_o  = raw & {NUM_SRC{~flush_i}};
  assign mdu_busy_o    = mduBusy;

  // Only long-latency producers claim an entry; ALU results are fully forwardable.
  assign dstTracked = !((ZERO_REG != 0) && (id_dst_addr_i == '0));
  assign writeIssue = issue & id_dst_we_i & dstTracked & (trackLoad | isMdu);
  assign mduLoad    = writeIssue & isMdu;
  assign dstLoadVal = isMdu ? MDU_VAL : LOAD_VAL;

  for (genvar r = 0; r < NUM_REGS; r++) begin : gReg
    if ((ZERO_REG != 0) && (r == 0)) begin : gZero
      assign regBusy[r] = 1'b0;
    end else begin : gCnt
      hazard_sb_entry #(.CW(CW)) uEntry (
        .clk    (clk_i),
        .rstN   (rst_i),
        .freeze (mem_stall_i),
        .load   (writeIssue && (id_dst_addr_i == REG_ADDR_W'(r))),
        .loadVal(dstLoadVal),
        .busy   (regBusy[r])
      );
    end
  end

  hazard_sb_entry #(.CW(CW)) uMduEntry (
    .clk    (clk_i),
    .rstN   (rst_i),
    .freeze (mem_stall_i),
    .load   (mduLoad),
    .loadVal(MDU_VAL),
    .busy   (mduBusy)
  );

endmodule
